// File: rtl/SB_codex_pkg.sv
// ---------------------------------------------------------------------------
// SB_codex_pkg
// Shared constants and types for the sideband codex and TX serializer.
//   SB_GAP_UI        : minimum idle UIs between sideband packets
//   SB_PKT_BITS_HDR  : length of a header-only packet
//   SB_PKT_BITS_FULL : length of a header + data packet
//   sb_tx_state_t    : serializer FSM states
// ---------------------------------------------------------------------------
package SB_codex_pkg;

    localparam int SB_GAP_UI        = 32;
    localparam int SB_PKT_BITS_HDR  = 64;
    localparam int SB_PKT_BITS_FULL = 128;

    typedef enum logic [1:0] {
        SB_TX_IDLE  = 2'd0,
        SB_TX_SHIFT = 2'd1,
        SB_TX_GAP   = 2'd2
    } sb_tx_state_t;

endpackage

// File: rtl/sb_tx_serializer.sv
// ---------------------------------------------------------------------------
// sb_tx_serializer
// Sideband transmit serializer. Accepts a complete 64- or 128-bit packet,
// shifts it out LSB-first with a forwarded strobe (one UI = 2 clocks), then
// holds both pins low for the mandatory inter-packet gap.
//
// Handshake: a packet transfers on a rising clk_800MHz edge where both
// msg_valid_i and msg_ready_o are high. The source holds msg_data_i and
// msg_len128_i stable while msg_valid_i is high and not yet accepted.
//
// Ports
//   clk_800MHz      in   sole clock
//   reset           in   synchronous, active-high
//   enable_i        in   permits acceptance of new packets
//   msg_data_i      in   packet bits, bit 0 sent first
//   msg_len128_i    in   1 = 128-bit packet, 0 = 64-bit packet
//   msg_valid_i     in   packet offered
//   msg_ready_o     out  serializer can accept a packet
//   msg_done_o      out  high in the last cycle of the last UI
//   busy_o          out  high while in SHIFT or GAP
//   SB_clkPin_TX_o  out  forwarded sideband clock (flop output)
//   SB_dataPin_TX_o out  sideband data (flop output)
// ---------------------------------------------------------------------------
module sb_tx_serializer
    import SB_codex_pkg::*;
#(
    parameter int GAP_UI   = SB_GAP_UI,
    parameter int MAX_BITS = SB_PKT_BITS_FULL
) (
    input  logic                clk_800MHz,
    input  logic                reset,
    input  logic                enable_i,
    input  logic [MAX_BITS-1:0] msg_data_i,
    input  logic                msg_len128_i,
    input  logic                msg_valid_i,
    output logic                msg_ready_o,
    output logic                msg_done_o,
    output logic                busy_o,
    output logic                SB_clkPin_TX_o,
    output logic                SB_dataPin_TX_o
);

    localparam int GAP_CYCLES = 2 * GAP_UI;
    localparam int GAP_W      = $clog2(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    sb_tx_state_t        state, nextState;
    logic [MAX_BITS-1:0] shiftReg, nextShiftReg;
    logic [7:0]          bitCnt, nextBitCnt;
    logic                phase, nextPhase;
    logic [GAP_W-1:0]    gapCnt, nextGapCnt;
    logic                busyQ, clkPinQ, dataPinQ;
    logic                accept;

    assign msg_ready_o = (state == SB_TX_IDLE) & enable_i & ~reset;
    assign accept      = msg_valid_i & msg_ready_o;

    // Phase 1 of the final bit: the strobe is high and the counter is on 1.
    assign msg_done_o  = (state == SB_TX_SHIFT) & phase & (bitCnt == 8'd1);

    assign busy_o          = busyQ;
    assign SB_clkPin_TX_o  = clkPinQ;
    assign SB_dataPin_TX_o = dataPinQ;

    always_comb begin
        nextState    = state;
        nextShiftReg = shiftReg;
        nextBitCnt   = bitCnt;
        nextPhase    = phase;
        nextGapCnt   = gapCnt;
        case (state)
            SB_TX_IDLE: begin
                if (accept) begin
                    nextState  = SB_TX_SHIFT;
                    nextPhase  = 1'b0;
                    if (msg_len128_i) begin
                        nextShiftReg = msg_data_i;
                        nextBitCnt   = 8'(SB_PKT_BITS_FULL);
                    end else begin
                        // Upper half is don't-care for a header-only packet.
                        nextShiftReg = {{(MAX_BITS-SB_PKT_BITS_HDR){1'b0}},
                                        msg_data_i[SB_PKT_BITS_HDR-1:0]};
                        nextBitCnt   = 8'(SB_PKT_BITS_HDR);
                    end
                end
            end
            SB_TX_SHIFT: begin
                if (!phase) begin
                    nextPhase = 1'b1;
                end else begin
                    nextPhase    = 1'b0;
                    nextShiftReg = shiftReg >> 1;
                    nextBitCnt   = bitCnt - 8'd1;
                    if (bitCnt == 8'd1) begin
                        nextState  = SB_TX_GAP;
                        nextGapCnt = GAP_LOAD;
                    end
                end
            end
            SB_TX_GAP: begin
                if (gapCnt == '0) begin
                    nextState = SB_TX_IDLE;
                end else begin
                    nextGapCnt = gapCnt - 1'b1;
                end
            end
            default: begin
                nextState = SB_TX_IDLE;
            end
        endcase
    end

    // Pins and busy are registered from the next-state view so that they are
    // aligned with the state the FSM occupies during the same cycle.
    always_ff @(posedge clk_800MHz) begin
        if (reset) begin
            state    <= SB_TX_IDLE;
            shiftReg <= '0;
            bitCnt   <= '0;
            phase    <= 1'b0;
            gapCnt   <= '0;
            busyQ    <= 1'b0;
            clkPinQ  <= 1'b0;
            dataPinQ <= 1'b0;
        end else begin
            state    <= nextState;
            shiftReg <= nextShiftReg;
            bitCnt   <= nextBitCnt;
            phase    <= nextPhase;
            gapCnt   <= nextGapCnt;
            busyQ    <= (nextState != SB_TX_IDLE);
            clkPinQ  <= (nextState == SB_TX_SHIFT) & nextPhase;
            dataPinQ <= (nextState == SB_TX_SHIFT) & nextShiftReg[0];
        end
    end

endmodule

// File: tb/tb_sb_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_sb_tx_serializer
// Self-checking bench for sb_tx_serializer. A reference model tracks the
// number of cycles since acceptance and derives every pin from that count;
// a scoreboard reassembles the bits seen on strobe rising edges and compares
// them with the packets accepted.
// ---------------------------------------------------------------------------
module tb_sb_tx_serializer;

    localparam int GAP_UI  = 32;
    localparam int GAP_CYC = 2 * GAP_UI;

    // ---------------- clock / reset ----------------
    logic         clk_800MHz = 1'b0;
    logic         reset;
    logic         enable_i;
    logic [127:0] msg_data_i;
    logic         msg_len128_i;
    logic         msg_valid_i;
    logic         msg_ready_o;
    logic         msg_done_o;
    logic         busy_o;
    logic         SB_clkPin_TX_o;
    logic         SB_dataPin_TX_o;

    always #5 clk_800MHz = ~clk_800MHz;

    sb_tx_serializer #(.GAP_UI(GAP_UI), .MAX_BITS(128)) dut (
        .clk_800MHz      (clk_800MHz),
        .reset           (reset),
        .enable_i        (enable_i),
        .msg_data_i      (msg_data_i),
        .msg_len128_i    (msg_len128_i),
        .msg_valid_i     (msg_valid_i),
        .msg_ready_o     (msg_ready_o),
        .msg_done_o      (msg_done_o),
        .busy_o          (busy_o),
        .SB_clkPin_TX_o  (SB_clkPin_TX_o),
        .SB_dataPin_TX_o (SB_dataPin_TX_o)
    );

    // ---------------- model / scoreboard state ----------------
    int errCount   = 0;
    int checkCount = 0;
    int cycleNum   = 0;

    int           age = 0;          // cycles since acceptance, 0 = idle
    int           curLen = 0;
    logic [127:0] curPkt = '0;
    int           lastAcceptCycle = 0;
    int           prevAcceptCycle = 0;

    logic [127:0] exp_q[$];
    int           expLen_q[$];
    logic [127:0] capWord = '0;
    int           capN = 0;
    logic         prevClkPin = 1'b0;

    task automatic checkVal(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cycleNum);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model, end at
    // the next falling edge where the caller may change inputs.
    task automatic tick();
        logic         expData, expClk, expDone, expBusy, expReady;
        logic [127:0] e;
        int           l;
        #1;
        expBusy  = (age > 0);
        expClk   = (age > 0) && (age <= 2 * curLen) && (age % 2 == 0);
        expData  = ((age > 0) && (age <= 2 * curLen)) ? curPkt[(age - 1) / 2] : 1'b0;
        expDone  = (age > 0) && (age == 2 * curLen);
        expReady = (age == 0) && enable_i && !reset;
        checkVal("busy",    busy_o,          expBusy);
        checkVal("clkPin",  SB_clkPin_TX_o,  expClk);
        checkVal("dataPin", SB_dataPin_TX_o, expData);
        checkVal("done",    msg_done_o,      expDone);
        checkVal("ready",   msg_ready_o,     expReady);

        if (SB_clkPin_TX_o === 1'b1 && prevClkPin === 1'b0) begin
            if (capN < 128) capWord[capN] = SB_dataPin_TX_o;
            capN++;
        end
        prevClkPin = SB_clkPin_TX_o;
        if (msg_done_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkVal("done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                l = expLen_q.pop_front();
                checkVal("pkt_bits", capWord, e);
                checkVal("pkt_len",  capN,    l);
            end
            capN    = 0;
            capWord = '0;
        end

        if (reset) begin
            age = 0;
            exp_q.delete();
            expLen_q.delete();
            capN    = 0;
            capWord = '0;
        end else if (age == 0) begin
            if (expReady && msg_valid_i) begin
                age    = 1;
                curLen = msg_len128_i ? 128 : 64;
                curPkt = msg_len128_i ? msg_data_i : {64'b0, msg_data_i[63:0]};
                exp_q.push_back(curPkt);
                expLen_q.push_back(curLen);
                prevAcceptCycle = lastAcceptCycle;
                lastAcceptCycle = cycleNum;
            end
        end else begin
            age++;
            if (age > 2 * curLen + GAP_CYC) age = 0;
        end
        cycleNum++;
        @(negedge clk_800MHz);
    endtask

    // ---------------- driver tasks ----------------
    task automatic waitAccept(input int bound);
        int n = 0;
        while (n < bound) begin
            tick();
            n++;
            if (age == 1) break;
        end
        if (age != 1) checkVal("accept_timeout", 0, 1);
    endtask

    task automatic sendPacket(input logic [127:0] data, input logic len128);
        msg_data_i   = data;
        msg_len128_i = len128;
        msg_valid_i  = 1'b1;
        waitAccept(2000);
        msg_valid_i  = 1'b0;
        msg_data_i   = {$urandom, $urandom, $urandom, $urandom};
        msg_len128_i = 1'($urandom_range(0, 1));
    endtask

    task automatic runIdle(input int bound);
        int n = 0;
        while (age != 0 && n < bound) begin
            tick();
            n++;
        end
        if (age != 0) checkVal("idle_timeout", 0, 1);
    endtask

    task automatic runUntilAge(input int target);
        int n = 0;
        while (age < target && n < 1000) begin
            tick();
            n++;
        end
        if (age != target) checkVal("age_timeout", age, target);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        enable_i     = 1'b1;
        msg_valid_i  = 1'b0;
        msg_data_i   = '0;
        msg_len128_i = 1'b0;
        @(negedge clk_800MHz);

        // Reset release
        repeat (10) tick();
        reset = 1'b0;
        repeat (3) tick();

        // 64-bit directed packet
        sendPacket(128'h0000_0000_0000_0000_A5A5_0000_FFFF_1234, 1'b0);
        runIdle(1000);
        repeat (2) tick();

        // 128-bit alternating pattern
        sendPacket({8{16'h5555}}, 1'b1);
        runIdle(1000);
        tick();

        // Back-to-back with valid held high
        msg_len128_i = 1'b0;
        msg_data_i   = {64'b0, 64'hDEAD_BEEF_0BAD_F00D};
        msg_valid_i  = 1'b1;
        waitAccept(10);
        msg_data_i   = {64'b0, 64'h1357_9BDF_2468_ACE0};
        waitAccept(400);
        checkVal("b2b_interval", lastAcceptCycle - prevAcceptCycle, 193);
        msg_valid_i  = 1'b0;
        runIdle(1000);

        // Enable gating: drop enable mid-packet, keep a packet pending
        sendPacket({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        runUntilAge(50);
        enable_i     = 1'b0;
        msg_data_i   = {64'b0, 64'hCAFE_0001_8000_7FFF};
        msg_len128_i = 1'b0;
        msg_valid_i  = 1'b1;
        runIdle(1000);
        repeat (6) tick();
        checkVal("held_while_disabled", age, 0);
        enable_i = 1'b1;
        waitAccept(3);
        msg_valid_i = 1'b0;
        runIdle(1000);

        // Mid-packet reset, then a clean packet
        sendPacket({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        runUntilAge(70);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        sendPacket({64'b0, 64'h0123_4567_89AB_CDEF}, 1'b0);
        runIdle(1000);

        // Randomized packets with random enable toggling
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 4)) tick();
            sendPacket({$urandom, $urandom, $urandom, $urandom},
                       1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 300)) begin
                enable_i = ($urandom_range(0, 7) != 0);
                tick();
            end
            enable_i = 1'b1;
            runIdle(1000);
        end

        repeat (3) tick();
        checkVal("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycleNum);
        $fatal(1, "watchdog");
    end

endmodule
